// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide SPI master.
package spi_pkg;
  localparam int BYTE_W      = 8;
  localparam int CMD_SS      = 0;
  localparam int CMD_OVR_CLR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/spi_clkgen.sv
// SCLK divider: toggles sclk every CLK_DIV enabled cycles, flags which edge is next.
// Held in reset (count 0, sclk low) whenever en_i is low.
module spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       tick;

  assign tick        = en_i && (cnt_q == DIV_LAST);
  assign rise_tick_o = tick && !sclk_q;
  assign fall_tick_o = tick && sclk_q;
  assign sclk_o      = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = 8'd0;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = 8'd0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= 8'd0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first byte SPI master driven by APB bridge strobes (cmd/wr/rd).
// One byte per wr; status flags busy/rx_valid/ovr for the bridge status register.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd,
  input  logic              wr,
  input  logic              rd,
  input  logic [BYTE_W-1:0] dout,
  output logic [BYTE_W-1:0] din,
  output logic              busy,
  output logic              rx_valid,
  output logic              ovr,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              ss_n
);
  state_t            state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] din_q, din_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              mosi_q, mosi_d;
  logic              ss_n_q, ss_n_d;
  logic              rx_valid_q, rx_valid_d;
  logic              ovr_q, ovr_d;
  logic              rise_tick, fall_tick;
  logic              busy_w;

  assign busy_w = (state_q != IDLE);

  spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q == XFER),
    .sclk_o      (sclk),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    din_d      = din_q;
    bit_cnt_d  = bit_cnt_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = ovr_q;

    case (state_q)
      IDLE: begin
        if (wr) begin
          shift_d   = dout;
          mosi_d    = dout[BYTE_W-1];
          bit_cnt_d = 3'd0;
          state_d   = XFER;
        end
      end
      XFER: begin
        if (rise_tick) shift_d = {shift_q[BYTE_W-2:0], miso};
        // The 8th falling edge ends the byte; mosi keeps the last bit sent.
        if (fall_tick) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            mosi_d    = shift_q[BYTE_W-1];
          end
        end
      end
      DONE: begin
        din_d   = shift_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cmd && !busy_w)            ss_n_d     = ~dout[CMD_SS];
    if (rd)                        rx_valid_d = 1'b0;
    if (cmd && dout[CMD_OVR_CLR])  ovr_d      = 1'b0;
    if (wr && busy_w)              ovr_d      = 1'b1;
    // Completion outranks a coincident rd, and error sets outrank a clear.
    if (state_q == DONE) begin
      rx_valid_d = 1'b1;
      if (rx_valid_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      din_q      <= '0;
      bit_cnt_q  <= 3'd0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      din_q      <= din_d;
      bit_cnt_q  <= bit_cnt_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign din      = din_q;
  assign busy     = busy_w;
  assign rx_valid = rx_valid_q;
  assign ovr      = ovr_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=4 and CLK_DIV=1) behind a selector,
// a mode-0 slave model on miso, and a flag-level reference model of the status bits.
module tb_spi_master;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] dout = 8'h00;
  bit         sel = 1'b0;
  bit         loop_q = 1'b0;
  logic [7:0] slv = 8'h00;

  logic [7:0] din4, din1;
  logic busy4, busy1, rxv4, rxv1, ovr4, ovr1, sclk4, sclk1, mosi4, mosi1, ssn4, ssn1;
  logic miso4, miso1;

  always #5 clk = ~clk;

  assign miso4 = loop_q ? mosi4 : slv[7];
  assign miso1 = loop_q ? mosi1 : slv[7];

  spi_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .cmd(cmd && !sel), .wr(wr && !sel), .rd(rd && !sel),
    .dout(dout), .din(din4), .busy(busy4), .rx_valid(rxv4), .ovr(ovr4),
    .sclk(sclk4), .mosi(mosi4), .miso(miso4), .ss_n(ssn4));

  spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .cmd(cmd && sel), .wr(wr && sel), .rd(rd && sel),
    .dout(dout), .din(din1), .busy(busy1), .rx_valid(rxv1), .ovr(ovr1),
    .sclk(sclk1), .mosi(mosi1), .miso(miso1), .ss_n(ssn1));

  logic [7:0] din_s;
  logic busy_s, rxv_s, ovr_s, sclk_s, mosi_s, ssn_s;
  assign din_s  = sel ? din1  : din4;
  assign busy_s = sel ? busy1 : busy4;
  assign rxv_s  = sel ? rxv1  : rxv4;
  assign ovr_s  = sel ? ovr1  : ovr4;
  assign sclk_s = sel ? sclk1 : sclk4;
  assign mosi_s = sel ? mosi1 : mosi4;
  assign ssn_s  = sel ? ssn1  : ssn4;

  // What the slave sees on mosi at each sclk rise, and the slave's own shifter.
  logic [7:0] mosi_cap = 8'h00;
  int         rise_cnt = 0;
  always @(posedge sclk_s) begin
    mosi_cap = {mosi_cap[6:0], mosi_s};
    rise_cnt = rise_cnt + 1;
  end
  always @(negedge sclk_s) slv = {slv[6:0], 1'b0};

  // Reference model per instance (index = sel).
  bit         rxv_m[2];
  bit         ovr_m[2];
  bit         ss_m[2];
  logic [7:0] din_m[2];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, sel ? 1 : 4, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rxv_m[i] = 1'b0; ovr_m[i] = 1'b0; ss_m[i] = 1'b1; din_m[i] = 8'h00;
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".din"}, din_s, din_m[sel]);
    check({tag, ".rx_valid"}, rxv_s, rxv_m[sel]);
    check({tag, ".ovr"}, ovr_s, ovr_m[sel]);
    check({tag, ".ss_n"}, ssn_s, ss_m[sel]);
  endtask

  task automatic do_cmd(input logic [7:0] v);
    cmd = 1'b1; dout = v;
    step();
    cmd = 1'b0;
    ss_m[sel] = ~v[0];
    if (v[1]) ovr_m[sel] = 1'b0;
    check("cmd.ss_n", ssn_s, ss_m[sel]);
    check("cmd.ovr", ovr_s, ovr_m[sel]);
  endtask

  task automatic do_rd();
    rd = 1'b1;
    check("rd.rxv_before", rxv_s, rxv_m[sel]);
    step();
    rd = 1'b0;
    rxv_m[sel] = 1'b0;
    check("rd.rx_valid", rxv_s, 1'b0);
    check("rd.din", din_s, din_m[sel]);
  endtask

  // One byte transfer. inj: busy cycle at which a stray wr is issued (0 = none).
  // cinj: busy cycle at which cmd 8'h02 is issued (0 = none). with_cmd: cmd=1 alongside wr.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] rx, input bit lp,
                      input int inj, input int cinj, input bit with_cmd);
    int d;
    int cnt;
    logic [7:0] exp_rx;
    d = sel ? 1 : 4;
    loop_q = lp;
    slv = rx;
    rise_cnt = 0;
    mosi_cap = 8'h00;
    dout = tx; wr = 1'b1; cmd = with_cmd;
    step();
    wr = 1'b0; cmd = 1'b0;
    if (with_cmd) begin
      ss_m[sel] = ~tx[0];
      if (tx[1]) ovr_m[sel] = 1'b0;
      check("wr+cmd.ss_n", ssn_s, ss_m[sel]);
    end
    check("xfer.busy_start", busy_s, 1'b1);
    cnt = 0;
    while (busy_s && cnt < 16 * d + 20) begin
      cnt++;
      if (cnt == inj)  begin wr = 1'b1;  dout = 8'h22; ovr_m[sel] = 1'b1; end
      if (cnt == cinj) begin cmd = 1'b1; dout = 8'h02; ovr_m[sel] = 1'b0; end
      step();
      wr = 1'b0; cmd = 1'b0;
      if (cnt == inj)  check("xfer.ovr_on_busy_wr", ovr_s, 1'b1);
      if (cnt == cinj) check("xfer.busy_cmd_ss_n", ssn_s, ss_m[sel]);
    end
    exp_rx = lp ? tx : rx;
    if (rxv_m[sel]) ovr_m[sel] = 1'b1;
    rxv_m[sel] = 1'b1;
    din_m[sel] = exp_rx;
    check("xfer.busy_len", cnt, 16 * d + 1);
    check("xfer.sclk_rises", rise_cnt, 8);
    check("xfer.mosi_bits", mosi_cap, tx);
    check("xfer.mosi_hold", mosi_s, tx[0]);
    check("xfer.sclk_idle", sclk_s, 1'b0);
    check_flags("xfer");
  endtask

  typedef struct {
    bit         has_cmd;
    logic [7:0] cmdv;
    bit         rd_first;
    logic [7:0] rx;
    logic [7:0] e_din;
    bit         e_rxv;
    bit         e_ovr;
    bit         e_ssn;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int guard;
    vecs[0] = '{1'b0, 8'h00, 1'b1, 8'h81, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h7E, 8'h7E, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 8'hC3, 8'hC3, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h03, 1'b1, 8'h18, 8'h18, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h02, 1'b1, 8'hE7, 8'hE7, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h01, 1'b0, 8'h42, 8'h42, 1'b1, 1'b1, 1'b0};

    model_reset();
    repeat (2) step();
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      check("rst.sclk", sclk_s, 1'b0);
      check("rst.mosi", mosi_s, 1'b0);
      check("rst.busy", busy_s, 1'b0);
      check_flags("rst");
    end
    sel = 1'b0;
    rst = 1'b1;
    step();

    // Loopback A5 with slave selected.
    do_cmd(8'h01);
    xfer(8'hA5, 8'h00, 1'b1, 0, 0, 1'b0);
    // Slave pattern 3C, read acknowledge.
    do_rd();
    xfer(8'h00, 8'h3C, 1'b0, 0, 0, 1'b0);
    do_rd();
    // Stray wr mid-transfer, then ovr clear while still busy.
    xfer(8'h11, 8'h5A, 1'b0, 20, 40, 1'b0);
    check("t3.ovr_cleared", ovr_s, 1'b0);
    check("t3.ss_n_kept", ssn_s, 1'b0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].has_cmd) do_cmd(vecs[i].cmdv);
      if (vecs[i].rd_first) do_rd();
      xfer(~vecs[i].rx, vecs[i].rx, 1'b0, 0, 0, 1'b0);
      check("vec.din", din_s, vecs[i].e_din);
      check("vec.rx_valid", rxv_s, vecs[i].e_rxv);
      check("vec.ovr", ovr_s, vecs[i].e_ovr);
      check("vec.ss_n", ssn_s, vecs[i].e_ssn);
    end

    // Async reset at the 5th sclk rise, then a clean transfer.
    do_cmd(8'h01);
    slv = 8'h99; loop_q = 1'b0; rise_cnt = 0;
    dout = 8'hC6; wr = 1'b1;
    step();
    wr = 1'b0;
    guard = 0;
    while (rise_cnt < 5 && guard < 100) begin step(); guard++; end
    check("t5.reached_rise5", rise_cnt, 5);
    rst = 1'b0;
    #1;
    model_reset();
    check("t5.sclk", sclk_s, 1'b0);
    check("t5.busy", busy_s, 1'b0);
    check_flags("t5");
    rst = 1'b1;
    step();
    xfer(8'h6D, 8'hB2, 1'b0, 0, 0, 1'b0);

    // CLK_DIV=1 instance: cmd and wr in the same idle cycle.
    sel = 1'b1;
    xfer(8'hFF, 8'h96, 1'b0, 0, 0, 1'b1);

    // Randomized traffic across both instances.
    for (int i = 0; i < 24; i++) begin
      int d;
      int inj;
      sel = $urandom_range(0, 1);
      d = sel ? 1 : 4;
      if ($urandom_range(0, 2) == 0) do_cmd({6'b0, 1'($urandom_range(0, 1)), 1'b1});
      if ($urandom_range(0, 1) == 0) do_rd();
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16 * d + 1) : 0;
      xfer(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), inj, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
